// File: rtl/prt_slot_scheduler_if.sv
// Slot-scheduler handshake bundle: RX allocation, firewall verdicts, TX sequencing and status.
// master = scheduler side, slave = RX/firewall/TX client side.
interface prt_slot_scheduler_if #(
    parameter int TAG_W = 2
);
    logic             alloc_req;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             rx_done;
    logic             rx_abort;
    logic [TAG_W-1:0] rx_tag;
    logic             verdict_valid;
    logic [TAG_W-1:0] verdict_tag;
    logic             verdict_safe;
    logic             tx_start;
    logic [TAG_W-1:0] tx_tag;
    logic             tx_done;
    logic             invalidate_valid;
    logic [TAG_W-1:0] invalidate_tag;
    logic             slot_available;
    logic [TAG_W:0]   free_count;
    logic             err_sticky;

    modport master (
        input  alloc_req, rx_done, rx_abort, rx_tag,
        input  verdict_valid, verdict_tag, verdict_safe, tx_done,
        output alloc_gnt, alloc_tag, tx_start, tx_tag,
        output invalidate_valid, invalidate_tag, slot_available, free_count, err_sticky
    );

    modport slave (
        output alloc_req, rx_done, rx_abort, rx_tag,
        output verdict_valid, verdict_tag, verdict_safe, tx_done,
        input  alloc_gnt, alloc_tag, tx_start, tx_tag,
        input  invalidate_valid, invalidate_tag, slot_available, free_count, err_sticky
    );
endinterface

// File: rtl/prt_slot_scheduler.sv
// Packet reference table slot lifecycle: FREE -> RX -> CHECK -> TXQ -> FREE, with an in-order
// TX queue of safe slots and a two-state TX sequencer. All outputs registered.
module prt_slot_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int TAG_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    prt_slot_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_RX    = 2'd1,
        S_CHECK = 2'd2,
        S_TXQ   = 2'd3
    } slot_e;

    typedef enum logic {
        TX_IDLE   = 1'b0,
        TX_ACTIVE = 1'b1
    } tx_e;

    slot_e            slot_q [NUM_SLOTS];
    slot_e            slot_d [NUM_SLOTS];
    tx_e              tx_state_q, tx_state_d;
    logic [TAG_W-1:0] qmem_q [NUM_SLOTS];
    logic [TAG_W-1:0] qmem_d [NUM_SLOTS];
    logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_W:0]   qcnt_q, qcnt_d;
    logic             alloc_gnt_q, alloc_gnt_d;
    logic [TAG_W-1:0] alloc_tag_q, alloc_tag_d;
    logic             tx_start_q, tx_start_d;
    logic [TAG_W-1:0] tx_tag_q, tx_tag_d;
    logic             inv_vld_q, inv_vld_d;
    logic [TAG_W-1:0] inv_tag_q, inv_tag_d;
    logic             avail_q, avail_d;
    logic [TAG_W:0]   free_cnt_q, free_cnt_d;
    logic             err_q, err_d;

    logic             free_found;
    logic [TAG_W-1:0] free_idx;
    logic             push, pop;

    always_comb begin
        slot_d      = slot_q;
        qmem_d      = qmem_q;
        tx_state_d  = tx_state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        qcnt_d      = qcnt_q;
        alloc_gnt_d = 1'b0;
        alloc_tag_d = alloc_tag_q;
        tx_start_d  = 1'b0;
        tx_tag_d    = tx_tag_q;
        inv_vld_d   = 1'b0;
        inv_tag_d   = inv_tag_q;
        err_d       = err_q;
        free_found  = 1'b0;
        free_idx    = '0;
        push        = 1'b0;
        pop         = 1'b0;
        free_cnt_d  = '0;

        // Descending scan so the last hit is the lowest-index FREE slot.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_q[i] == S_FREE) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
        end

        if (bus.alloc_req && !alloc_gnt_q && free_found) begin
            alloc_gnt_d      = 1'b1;
            alloc_tag_d      = free_idx;
            slot_d[free_idx] = S_RX;
        end

        if (bus.rx_done && bus.rx_abort) begin
            err_d = 1'b1;
        end else if (bus.rx_done || bus.rx_abort) begin
            if (slot_q[bus.rx_tag] != S_RX) begin
                err_d = 1'b1;
            end else begin
                slot_d[bus.rx_tag] = bus.rx_done ? S_CHECK : S_FREE;
            end
        end

        if (bus.verdict_valid) begin
            if (slot_q[bus.verdict_tag] != S_CHECK) begin
                err_d = 1'b1;
            end else if (bus.verdict_safe) begin
                slot_d[bus.verdict_tag] = S_TXQ;
                qmem_d[wr_ptr_q]        = bus.verdict_tag;
                wr_ptr_d                = wr_ptr_q + TAG_W'(1);
                push                    = 1'b1;
            end else begin
                slot_d[bus.verdict_tag] = S_FREE;
                inv_vld_d               = 1'b1;
                inv_tag_d               = bus.verdict_tag;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_done) begin
                    err_d = 1'b1;
                end
                if (qcnt_q != '0) begin
                    tx_start_d = 1'b1;
                    tx_tag_d   = qmem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + TAG_W'(1);
                    pop        = 1'b1;
                    tx_state_d = TX_ACTIVE;
                end
            end
            TX_ACTIVE: begin
                if (bus.tx_done) begin
                    slot_d[tx_tag_q] = S_FREE;
                    tx_state_d       = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        case ({push, pop})
            2'b10:   qcnt_d = qcnt_q + (TAG_W+1)'(1);
            2'b01:   qcnt_d = qcnt_q - (TAG_W+1)'(1);
            default: qcnt_d = qcnt_q;
        endcase

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_d[i] == S_FREE) begin
                free_cnt_d = free_cnt_d + (TAG_W+1)'(1);
            end
        end
        avail_d = (free_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= S_FREE;
                qmem_q[i] <= '0;
            end
            tx_state_q  <= TX_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            qcnt_q      <= '0;
            alloc_gnt_q <= 1'b0;
            alloc_tag_q <= '0;
            tx_start_q  <= 1'b0;
            tx_tag_q    <= '0;
            inv_vld_q   <= 1'b0;
            inv_tag_q   <= '0;
            avail_q     <= 1'b1;
            free_cnt_q  <= (TAG_W+1)'(NUM_SLOTS);
            err_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            qmem_q      <= qmem_d;
            tx_state_q  <= tx_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            qcnt_q      <= qcnt_d;
            alloc_gnt_q <= alloc_gnt_d;
            alloc_tag_q <= alloc_tag_d;
            tx_start_q  <= tx_start_d;
            tx_tag_q    <= tx_tag_d;
            inv_vld_q   <= inv_vld_d;
            inv_tag_q   <= inv_tag_d;
            avail_q     <= avail_d;
            free_cnt_q  <= free_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.alloc_gnt        = alloc_gnt_q;
    assign bus.alloc_tag        = alloc_tag_q;
    assign bus.tx_start         = tx_start_q;
    assign bus.tx_tag           = tx_tag_q;
    assign bus.invalidate_valid = inv_vld_q;
    assign bus.invalidate_tag   = inv_tag_q;
    assign bus.slot_available   = avail_q;
    assign bus.free_count       = free_cnt_q;
    assign bus.err_sticky       = err_q;
endmodule

// File: tb/tb_prt_slot_scheduler.sv
// Directed bench for prt_slot_scheduler: allocation, safe/unsafe verdicts, TX ordering,
// abort and illegal-event handling, asynchronous reset mid-operation.
module tb_prt_slot_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    prt_slot_scheduler_if #(.TAG_W(2)) bus ();

    prt_slot_scheduler #(.NUM_SLOTS(4), .TAG_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_gnt"},   32'(bus.alloc_gnt),        0);
        chk({pfx, "_atag"},  32'(bus.alloc_tag),        0);
        chk({pfx, "_txs"},   32'(bus.tx_start),         0);
        chk({pfx, "_txtag"}, 32'(bus.tx_tag),           0);
        chk({pfx, "_inv"},   32'(bus.invalidate_valid), 0);
        chk({pfx, "_itag"},  32'(bus.invalidate_tag),   0);
        chk({pfx, "_avail"}, 32'(bus.slot_available),   1);
        chk({pfx, "_fc"},    32'(bus.free_count),       4);
        chk({pfx, "_err"},   32'(bus.err_sticky),       0);
    endtask

    initial begin
        bus.alloc_req     = 1'b0;
        bus.rx_done       = 1'b0;
        bus.rx_abort      = 1'b0;
        bus.rx_tag        = '0;
        bus.verdict_valid = 1'b0;
        bus.verdict_tag   = '0;
        bus.verdict_safe  = 1'b0;
        bus.tx_done       = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs("rst");

        // Held request: grants 0..3 on alternate cycles, then stall.
        bus.alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("alloc%0d_gnt", k), 32'(bus.alloc_gnt), 1);
            chk($sformatf("alloc%0d_tag", k), 32'(bus.alloc_tag), 32'(k));
            chk($sformatf("alloc%0d_fc", k),  32'(bus.free_count), 32'(3 - k));
            step();
            chk($sformatf("alloc%0d_gap", k), 32'(bus.alloc_gnt), 0);
        end
        chk("full_avail", 32'(bus.slot_available), 0);
        step();
        chk("stall_gnt1", 32'(bus.alloc_gnt), 0);
        step();
        chk("stall_gnt2", 32'(bus.alloc_gnt), 0);
        bus.alloc_req = 1'b0;

        // Slot 1 safe path.
        bus.rx_done = 1'b1; bus.rx_tag = 2'd1;
        step();
        bus.rx_done = 1'b0;
        bus.verdict_valid = 1'b1; bus.verdict_tag = 2'd1; bus.verdict_safe = 1'b1;
        step();
        bus.verdict_valid = 1'b0;
        chk("s1_nostart", 32'(bus.tx_start), 0);
        step();
        chk("s1_txs", 32'(bus.tx_start), 1);
        chk("s1_txtag", 32'(bus.tx_tag), 1);
        step();
        chk("s1_txs_pulse", 32'(bus.tx_start), 0);
        chk("s1_txtag_hold", 32'(bus.tx_tag), 1);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("s1_fc", 32'(bus.free_count), 1);
        chk("s1_avail", 32'(bus.slot_available), 1);

        // Slot 2 unsafe path, then re-grant of freed slots.
        bus.rx_done = 1'b1; bus.rx_tag = 2'd2;
        step();
        bus.rx_done = 1'b0;
        bus.verdict_valid = 1'b1; bus.verdict_tag = 2'd2; bus.verdict_safe = 1'b0;
        step();
        bus.verdict_valid = 1'b0;
        chk("s2_inv", 32'(bus.invalidate_valid), 1);
        chk("s2_itag", 32'(bus.invalidate_tag), 2);
        chk("s2_fc", 32'(bus.free_count), 2);
        chk("s2_notx", 32'(bus.tx_start), 0);
        step();
        chk("s2_inv_pulse", 32'(bus.invalidate_valid), 0);
        bus.alloc_req = 1'b1;
        step();
        chk("regnt_a_tag", 32'(bus.alloc_tag), 1);
        step();
        step();
        chk("regnt_b_gnt", 32'(bus.alloc_gnt), 1);
        chk("regnt_b_tag", 32'(bus.alloc_tag), 2);
        chk("regnt_fc", 32'(bus.free_count), 0);
        bus.alloc_req = 1'b0;

        // Safe verdicts 3,0,2 must start TX in that order.
        bus.rx_done = 1'b1; bus.rx_tag = 2'd3;
        step();
        bus.rx_tag = 2'd0;
        step();
        bus.rx_tag = 2'd2;
        step();
        bus.rx_done = 1'b0;
        bus.verdict_valid = 1'b1; bus.verdict_safe = 1'b1; bus.verdict_tag = 2'd3;
        step();
        bus.verdict_tag = 2'd0;
        step();
        chk("ord0_txs", 32'(bus.tx_start), 1);
        chk("ord0_tag", 32'(bus.tx_tag), 3);
        bus.verdict_tag = 2'd2;
        step();
        bus.verdict_valid = 1'b0;
        chk("ord0_busy", 32'(bus.tx_start), 0);
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("ord1_gap", 32'(bus.tx_start), 0);
        chk("ord1_fc", 32'(bus.free_count), 1);
        step();
        chk("ord1_txs", 32'(bus.tx_start), 1);
        chk("ord1_tag", 32'(bus.tx_tag), 0);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        step();
        chk("ord2_txs", 32'(bus.tx_start), 1);
        chk("ord2_tag", 32'(bus.tx_tag), 2);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("ord_fc", 32'(bus.free_count), 3);
        chk("ord_err", 32'(bus.err_sticky), 0);

        // Abort slot 0 during RX, then an illegal verdict for it.
        bus.alloc_req = 1'b1;
        step();
        bus.alloc_req = 1'b0;
        chk("ab_gnt_tag", 32'(bus.alloc_tag), 0);
        chk("ab_fc0", 32'(bus.free_count), 2);
        bus.rx_abort = 1'b1; bus.rx_tag = 2'd0;
        step();
        bus.rx_abort = 1'b0;
        chk("ab_fc1", 32'(bus.free_count), 3);
        chk("ab_noinv", 32'(bus.invalidate_valid), 0);
        chk("ab_err0", 32'(bus.err_sticky), 0);
        bus.verdict_valid = 1'b1; bus.verdict_tag = 2'd0; bus.verdict_safe = 1'b1;
        step();
        bus.verdict_valid = 1'b0;
        chk("ab_err1", 32'(bus.err_sticky), 1);
        step();
        chk("ab_notx", 32'(bus.tx_start), 0);
        chk("ab_err_sticky", 32'(bus.err_sticky), 1);

        // Build TX active on slot 1 with slots 0 and 2 in CHECK, then reset.
        bus.alloc_req = 1'b1;
        step();
        chk("rs_gnt0", 32'(bus.alloc_tag), 0);
        step();
        step();
        chk("rs_gnt2", 32'(bus.alloc_tag), 2);
        bus.alloc_req = 1'b0;
        bus.rx_done = 1'b1; bus.rx_tag = 2'd1;
        step();
        bus.rx_done = 1'b0;
        bus.verdict_valid = 1'b1; bus.verdict_tag = 2'd1; bus.verdict_safe = 1'b1;
        step();
        bus.verdict_valid = 1'b0;
        bus.rx_done = 1'b1; bus.rx_tag = 2'd0;
        step();
        chk("rs_txs", 32'(bus.tx_start), 1);
        bus.rx_tag = 2'd2;
        step();
        bus.rx_done = 1'b0;
        chk("rs_txtag", 32'(bus.tx_tag), 1);
        chk("rs_fc_pre", 32'(bus.free_count), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        step();
        rst = 1'b0;
        step();
        chk("post_notx", 32'(bus.tx_start), 0);
        chk("post_fc", 32'(bus.free_count), 4);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("idle_txdone_err", 32'(bus.err_sticky), 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
